// File: rtl/alu32_seq.sv
// alu32_seq -- byte-serial 32-bit ALU.
//
// Computes one WIDTH-bit AND / OR / ADD / SLT result over WIDTH/8 beats,
// least-significant byte first, with a registered carry between beats.
// Operand and control encoding match the combinational 8-bit ALU slice:
// a = src1 ^ A_invert, b = src2 ^ B_invert, carry into bit 0 = cin.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   request an operation (accepted when busy = 0)
//   src1/src2  in   operands, captured on an accepted start
//   A_invert   in   invert operand A
//   B_invert   in   invert operand B
//   cin        in   carry into bit 0 (1 for SUB and SLT)
//   operation  in   00 AND, 01 OR, 10 ADD, 11 SLT
//   busy       out  operation in progress
//   done       out  one-cycle pulse; result and flags valid
//   result     out  result register
//   zero       out  result == 0
//   overflow   out  signed overflow (ADD only)
//   cout       out  carry out of the MSB (ADD only)
module alu32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             A_invert,
  input  logic             B_invert,
  input  logic             cin,
  input  logic [1:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam int BEATS  = WIDTH / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [BEAT_W-1:0]  beat_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               zero_reg;
  logic               overflow_reg;
  logic               cout_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               accept;
  logic [7:0]         a_bytes [BEATS];
  logic [7:0]         b_bytes [BEATS];
  logic [7:0]         a_byte;
  logic [7:0]         b_byte;
  logic [8:0]         sum9;
  logic [7:0]         byte_val;
  logic               c31;
  logic               ovf;
  logic               last_beat;

  // Split the latched operands into byte lanes so the active beat is a
  // simple array select.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign a_bytes[gi] = a_reg[gi*8 +: 8];
      assign b_bytes[gi] = b_reg[gi*8 +: 8];
    end
  endgenerate

  assign accept    = start && (state_reg != RUN);
  assign last_beat = (beat_reg == LAST_BEAT);

  // Byte slice for the current beat.
  always_comb begin
    a_byte   = a_bytes[beat_reg];
    b_byte   = b_bytes[beat_reg];
    sum9     = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_reg};
    // Carry into the top bit of the byte recovered from its sum bit.
    c31      = a_byte[7] ^ b_byte[7] ^ sum9[7];
    ovf      = c31 ^ sum9[8];
    byte_val = 8'h00;
    case (op_reg)
      OP_AND:  byte_val = a_byte & b_byte;
      OP_OR:   byte_val = a_byte | b_byte;
      OP_ADD:  byte_val = sum9[7:0];
      default: byte_val = 8'h00;  // SLT only tracks the carry chain
    endcase
  end

  // Result with the current beat's byte merged in.
  always_comb begin
    result_next = result_reg;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_reg == BEAT_W'(i)) begin
        result_next[i*8 +: 8] = byte_val;
      end
    end
    if (last_beat && (op_reg == OP_SLT)) begin
      // Signed less-than: sign of the sum corrected by overflow.
      result_next[0] = sum9[7] ^ ovf;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_beat) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= OP_AND;
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      overflow_reg <= 1'b0;
      cout_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
      if (accept) begin
        a_reg        <= src1 ^ {WIDTH{A_invert}};
        b_reg        <= src2 ^ {WIDTH{B_invert}};
        op_reg       <= operation;
        carry_reg    <= cin;
        beat_reg     <= '0;
        result_reg   <= '0;
        zero_reg     <= 1'b1;
        overflow_reg <= 1'b0;
        cout_reg     <= 1'b0;
      end else if (state_reg == RUN) begin
        result_reg <= result_next;
        carry_reg  <= sum9[8];
        beat_reg   <= beat_reg + 1'b1;
        if (last_beat) begin
          zero_reg     <= (result_next == '0);
          overflow_reg <= (op_reg == OP_ADD) && ovf;
          cout_reg     <= (op_reg == OP_ADD) && sum9[8];
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign zero     = zero_reg;
  assign overflow = overflow_reg;
  assign cout     = cout_reg;

endmodule

// File: tb/tb_alu32_seq.sv
// Testbench for alu32_seq: directed vectors with literal expectations,
// plus a cycle-level reference model checked on every falling edge.
module tb_alu32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src1, src2;
  logic        A_invert, B_invert, cin;
  logic [1:0]  operation;
  logic        busy, done, zero, overflow, cout;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  alu32_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src1(src1), .src2(src2), .A_invert(A_invert), .B_invert(B_invert),
    .cin(cin), .operation(operation),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .cout(cout)
  );

  always #5 clk = ~clk;

  // Arithmetic model: returns {overflow, cout, result}.
  function automatic logic [33:0] model_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ai, input logic bi,
                                           input logic ci, input logic [1:0] op);
    logic [31:0] a, b, r;
    logic [32:0] s;
    logic        v;
    a = ai ? ~x : x;
    b = bi ? ~y : y;
    s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    v = (a[31] == b[31]) && (s[31] != a[31]);
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = s[31:0];
      default: r = {31'd0, s[31] ^ v};
    endcase
    if (op == 2'b10) return {v, s[32], r};
    return {2'b00, r};
  endfunction

  // Cycle-level model: phase 0 idle, 1..4 running, 5 done.
  int          phase = 0;
  logic        model_ok = 1'b0;
  logic [33:0] pend;
  logic [31:0] exp_result = '0;
  logic        exp_ovf = 1'b0, exp_cout = 1'b0, exp_zero = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 0;
      model_ok   <= 1'b1;
      exp_result <= '0;
      exp_zero   <= 1'b1;
      exp_ovf    <= 1'b0;
      exp_cout   <= 1'b0;
    end else if ((phase == 0 || phase == 5) && start) begin
      phase <= 1;
      pend  <= model_op(src1, src2, A_invert, B_invert, cin, operation);
    end else if (phase >= 1 && phase <= 3) begin
      phase <= phase + 1;
    end else if (phase == 4) begin
      phase      <= 5;
      exp_result <= pend[31:0];
      exp_zero   <= (pend[31:0] == 32'd0);
      exp_ovf    <= pend[33];
      exp_cout   <= pend[32];
    end else if (phase == 5) begin
      phase <= 0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: handshake every cycle, result/flags when valid.
  always @(negedge clk) begin
    if (model_ok) begin
      cmp("busy", {31'd0, busy}, {31'd0, (phase >= 1 && phase <= 4)});
      cmp("done", {31'd0, done}, {31'd0, (phase == 5)});
      if (phase == 0 || phase == 5) begin
        cmp("model_result", result, exp_result);
        cmp("model_zero", {31'd0, zero}, {31'd0, exp_zero});
        cmp("model_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        cmp("model_cout", {31'd0, cout}, {31'd0, exp_cout});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ai,
                       input logic bi, input logic ci, input logic [1:0] op);
    src1 = x; src2 = y; A_invert = ai; B_invert = bi; cin = ci; operation = op;
    start = 1'b1;
  endtask

  // Let the issued start be sampled, then wait (bounded) for done.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b0;
        src1 = 32'hDEAD_BEEF; src2 = 32'h1357_9BDF;
        A_invert = 1'b1; B_invert = 1'b0; cin = 1'b1; operation = 2'b01;
      end
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, want done within 12 cycles");
    end
  endtask

  task automatic expect_out(input string name, input int n, input logic [31:0] r,
                            input logic v, input logic c, input logic z);
    cmp({name, "_latency"}, n, 5);
    cmp({name, "_result"}, result, r);
    cmp({name, "_overflow"}, {31'd0, overflow}, {31'd0, v});
    cmp({name, "_cout"}, {31'd0, cout}, {31'd0, c});
    cmp({name, "_zero"}, {31'd0, zero}, {31'd0, z});
    $display("op %s: result=0x%08h ovf=%0b cout=%0b zero=%0b latency=%0d",
             name, result, overflow, cout, zero, n);
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic ai, input logic bi, input logic ci,
                        input logic [1:0] op, input logic [31:0] r,
                        input logic v, input logic c, input logic z);
    int n;
    issue(x, y, ai, bi, ci, op);
    wait_done(n);
    expect_out(name, n, r, v, c, z);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    src1 = '0; src2 = '0; A_invert = 1'b0; B_invert = 1'b0; cin = 1'b0; operation = 2'b00;
    tick(); tick();
    cmp("reset_busy", {31'd0, busy}, 32'd0);
    cmp("reset_done", {31'd0, done}, 32'd0);
    cmp("reset_result", result, 32'd0);
    cmp("reset_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    tick();

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 2'b10, 32'h8000_0000, 1, 0, 0);
    run_op("sub_eq",  32'h1234_5678, 32'h1234_5678, 0, 1, 1, 2'b10, 32'h0000_0000, 0, 1, 1);
    run_op("slt_m1_1", 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 1, 2'b11, 32'd1, 0, 0, 0);
    run_op("slt_1_m1", 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 1, 2'b11, 32'd0, 0, 0, 1);
    run_op("slt_min_1", 32'h8000_0000, 32'h0000_0001, 0, 1, 1, 2'b11, 32'd1, 0, 0, 0);
    run_op("slt_max_m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, 2'b11, 32'd0, 0, 0, 1);
    run_op("nor", 32'h0, 32'h0, 1, 1, 0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 2'b00, 32'hF000_F000, 0, 0, 0);
    run_op("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 0, 2'b01, 32'hFFF0_FFF0, 0, 0, 0);
    // Logic op whose carry chain ends at 1, then an ADD that must see cin only.
    run_op("and_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 2'b00, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("add_zero", 32'h0, 32'h0, 0, 0, 0, 2'b10, 32'h0, 0, 0, 1);

    // start pulsed while busy must be ignored.
    issue(32'd5, 32'd3, 0, 0, 0, 2'b10);
    tick(); start = 1'b0;
    tick(); issue(32'h1111_1111, 32'h2222_2222, 0, 0, 0, 2'b01);
    tick(); src1 = 32'h4444_4444;
    tick();
    tick(); start = 1'b0;
    expect_out("ignore_busy", done ? 5 : 0, 32'd8, 0, 0, 0);
    tick();

    // start in the DONE cycle is accepted.
    issue(32'd10, 32'd20, 0, 0, 0, 2'b10);
    wait_done(n);
    expect_out("b2b_first", n, 32'd30, 0, 0, 0);
    issue(32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 2'b10);
    wait_done(n);
    expect_out("b2b_second", n, 32'h0001_0000, 0, 0, 0);
    tick();

    // Reset during beat 2 aborts the operation.
    issue(32'h0101_0101, 32'h0101_0101, 0, 0, 0, 2'b10);
    tick(); start = 1'b0;
    tick();
    tick(); rst_n = 1'b0;
    tick();
    cmp("abort_busy", {31'd0, busy}, 32'd0);
    cmp("abort_done", {31'd0, done}, 32'd0);
    cmp("abort_result", result, 32'd0);
    cmp("abort_zero", {31'd0, zero}, 32'd1);
    cmp("abort_overflow", {31'd0, overflow}, 32'd0);
    cmp("abort_cout", {31'd0, cout}, 32'd0);
    $display("op abort: busy=%0b done=%0b result=0x%08h zero=%0b", busy, done, result, zero);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op("add_after_reset", 32'd1, 32'd1, 0, 0, 0, 2'b10, 32'd2, 0, 0, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want $finish");
    $fatal(1, "watchdog");
  end

endmodule
